prefetch_queue: RTL
===================

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 Parameter WIDTH, default 32, meaning address and instruction width in bits.
REQ-002 Parameter DEPTH, default 4, meaning instruction queue entries; a power of two, at least 2.
REQ-003 Parameter RESET_PC, default 32'h00000000, meaning first fetch address after reset.
REQ-004 clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  meaning asynchronous, active-high reset.
REQ-006 imem_req  output  1  meaning instruction memory read request.
REQ-007 imem_addr  output  WIDTH  meaning fetch address; word aligned.
REQ-008 imem_ack  input  1  meaning memory completes the current request; data is valid this cycle.
REQ-009 imem_rdata  input  WIDTH  meaning instruction word returned with imem_ack.
REQ-010 redirect  input  1  meaning taken branch or jump; flush the queue and refetch.
REQ-011 redirect_pc  input  WIDTH  meaning new fetch address, sampled when redirect=1.
REQ-012 inst_valid  output  1  meaning the queue head holds an instruction.
REQ-013 inst_out  output  WIDTH  meaning the instruction at the queue head.
REQ-014 inst_pc  output  WIDTH  meaning the address of inst_out.
REQ-015 inst_ready  input  1  meaning the consumer accepts the head this cycle.
REQ-016 count  output  clog2(DEPTH)+1  meaning the number of valid queue entries.

Function
REQ-017 The block SHALL have two states: FETCH (normal) and DROP (discarding a stale in-flight request).
REQ-018 fetch_pc SHALL be a register, and imem_addr SHALL equal fetch_pc, except in DROP, where imem_addr SHALL equal the held stale address.
REQ-019 In FETCH, imem_req SHALL be 1 when count<DEPTH, or when a request is already pending; otherwise it SHALL be 0.
REQ-020 Once imem_req is asserted, imem_req and imem_addr SHALL stay stable until a cycle with imem_ack=1; a full queue never withdraws a pending request.
REQ-021 A transfer SHALL occur on any cycle with imem_req=1 and imem_ack=1; imem_ack may arrive in the same cycle as the request (zero-wait memory).
REQ-022 imem_ack while imem_req=0 SHALL be ignored.
REQ-023 On a transfer in FETCH with no redirect, the block SHALL push {fetch_pc, imem_rdata} and set fetch_pc <= fetch_pc+4, modulo 2^WIDTH.
REQ-024 A request SHALL be issued only when a queue slot is free for its data, so a push never meets a full queue.
REQ-025 A pop SHALL occur when inst_valid=1 and inst_ready=1; inst_valid SHALL equal (count!=0).
REQ-026 A simultaneous push and pop SHALL leave count unchanged.
REQ-027 inst_out and inst_pc SHALL be driven from the head entry, with no combinational path from imem_rdata.
REQ-028 The read and write pointers SHALL wrap modulo DEPTH.
REQ-029 On redirect=1, the block SHALL flush the queue (count<=0; any same-cycle pop or push is discarded) and set fetch_pc <= {redirect_pc[WIDTH-1:2],2'b00}.
REQ-030 Redirect with a pending request and imem_ack=0 in FETCH SHALL enter DROP.
REQ-031 In DROP, imem_req SHALL stay 1 at the stale address until imem_ack; that data SHALL be discarded, and the state SHALL return to FETCH next cycle.
REQ-032 Redirect with imem_ack=1 in the same cycle SHALL discard the returned data and stay in FETCH.
REQ-033 Redirect while in DROP SHALL update fetch_pc to the newest target and remain in DROP.
REQ-034 Latency: with zero-wait memory, an instruction at address A SHALL appear at inst_valid one cycle after its transfer; after a redirect, the first new instruction SHALL appear no earlier than 2 cycles later.

Reset
REQ-035 While reset=1, asynchronously: state=FETCH, fetch_pc=RESET_PC, count=0, pointers=0, inst_valid=0, imem_req=0, inst_out=0, inst_pc=0.
REQ-036 In the first cycle after reset deasserts, imem_req SHALL be 1 with imem_addr=RESET_PC.
REQ-037 Reset asserted mid-request SHALL abandon the request; memory SHALL treat the dropped imem_req as a cancel.

Verification
REQ-038 Fill: imem_ack tied 1, inst_ready=0, DEPTH=4 -> PCs 0,4,8,C queued, count=4, imem_req=0 with addr=0x10 held.
REQ-039 Streaming: imem_ack=1, inst_ready=1 -> after the first cycle, one instruction per cycle, inst_pc=0,4,8,... in order, count stays 1.
REQ-040 Wait states: imem_ack 3 cycles after req at 0x8 -> imem_req and addr=0x8 held stable for 3 cycles, single push of 0x8.
REQ-041 Redirect during a pending request: req at 0xC, imem_ack=0, redirect to 0x100 -> DROP, addr stays 0xC until ack, that data is discarded, next req at 0x100, count=0.
REQ-042 Simultaneous redirect, ack and pop with count=2 -> count=0, data discarded, next req at redirect_pc, inst_valid=0 next cycle.
REQ-043 Reset mid-stream with count=3 -> outputs at the REQ-035 values immediately, then first req at RESET_PC.

Source files
------------

// File: rtl/prefetch_queue.sv
// Instruction prefetch: sequential word fetch into a DEPTH-entry queue, flushed and refetched on redirect.
// Latency: a word reaches the head one cycle after its transfer; fetch stalls when no slot is free, consumer throttles via inst_ready.
module prefetch_queue #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [WIDTH-1:0]         imem_addr,
  input  logic                     imem_ack,
  input  logic [WIDTH-1:0]         imem_rdata,
  input  logic                     redirect,
  input  logic [WIDTH-1:0]         redirect_pc,
  output logic                     inst_valid,
  output logic [WIDTH-1:0]         inst_out,
  output logic [WIDTH-1:0]         inst_pc,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {FETCH = 1'b0, DROP = 1'b1} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] stale_pc;
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [WIDTH-1:0] pc_q  [DEPTH];
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic             push, pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_d;
  end

  always_comb begin
    state_d   = state;
    imem_req  = 1'b0;
    imem_addr = fetch_pc;
    case (state)
      FETCH: begin
        // count cannot rise while a request waits, so a pending request is never withdrawn
        imem_req = (count < CW'(DEPTH));
        if (redirect && imem_req && !imem_ack) state_d = DROP;
      end
      DROP: begin
        imem_req  = 1'b1;
        imem_addr = stale_pc;
        if (imem_ack) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (reset) imem_req = 1'b0;
  end

  assign push       = imem_req && imem_ack && (state == FETCH) && !redirect;
  assign pop        = inst_valid && inst_ready && !redirect;
  assign inst_valid = (count != '0);
  assign inst_out   = inst_valid ? dat_q[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? pc_q[rd_ptr]  : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      stale_pc <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (state == FETCH && state_d == DROP) stale_pc <= fetch_pc;
      if (redirect) begin
        fetch_pc <= redirect_pc & ~WIDTH'(3);
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + AW'(1);
          fetch_pc <= fetch_pc + WIDTH'(4);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]  <= fetch_pc;
      dat_q[wr_ptr] <= imem_rdata;
    end
  end

endmodule
